// File: rtl/centroid_marker_pkg.sv
// Shared definitions for the centroid marker: controller states and default overlay colour.
// Accumulator/divider width note: ACC_W must cover the largest first moment, i.e.
// ACC_W >= log2(H_ACTIVE * V_ACTIVE * max(H_ACTIVE, V_ACTIVE)) + 1.
package centroid_marker_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      DONE = 2'd2
   } state_t;

   localparam logic [23:0] MARK_COLOR_DEFAULT = 24'hFF0000;

endpackage

// File: rtl/centroid_marker_seq_divider.sv
// Restoring unsigned divider: one quotient bit per clock, W clocks per division.
// Quotient is shifted in over the dividend register; divisor is captured at start.
module seq_divider #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic         start,
   input  logic [W-1:0] dividend,
   input  logic [W-1:0] divisor,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int CNT_W = $clog2(W + 1);

   logic [W-1:0]     rem_reg;
   logic [W-1:0]     quo_reg;
   logic [W-1:0]     dvs_reg;
   logic [CNT_W-1:0] cnt_reg;
   logic [W:0]       rem_shift;
   logic [W:0]       diff;

   // Partial remainder with the next dividend bit shifted in, and the trial subtraction.
   assign rem_shift = {rem_reg, quo_reg[W-1]};
   assign diff      = rem_shift - {1'b0, dvs_reg};
   assign quotient  = quo_reg;

   // Load on start, then one restoring step per clock; done pulses after the last step.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_reg <= '0;
         quo_reg <= '0;
         dvs_reg <= '0;
         cnt_reg <= '0;
         busy    <= 1'b0;
         done    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (start && !busy) begin
            rem_reg <= '0;
            quo_reg <= dividend;
            dvs_reg <= divisor;
            cnt_reg <= CNT_W'(W);
            busy    <= 1'b1;
         end else if (busy) begin
            if (!diff[W]) begin
               rem_reg <= diff[W-1:0];
               quo_reg <= {quo_reg[W-2:0], 1'b1};
            end else begin
               rem_reg <= rem_shift[W-1:0];
               quo_reg <= {quo_reg[W-2:0], 1'b0};
            end
            cnt_reg <= cnt_reg - CNT_W'(1);
            if (cnt_reg == CNT_W'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/centroid_marker.sv
// Centroid marker: accumulates mask moments per frame, divides at frame end and
// overlays a cross at the last valid centroid on the (1-clk delayed) video.
module centroid_marker
   import centroid_marker_pkg::*;
#(
   parameter int          H_ACTIVE   = 64,
   parameter int          V_ACTIVE   = 64,
   parameter int          COORD_W    = 11,
   parameter int          ACC_W      = 32,
   parameter int          MIN_AREA   = 16,
   parameter logic [23:0] MARK_COLOR = MARK_COLOR_DEFAULT
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               de,
   input  logic               hsync,
   input  logic               vsync,
   input  logic [23:0]        pixel_in,
   output logic               de_out,
   output logic               hsync_out,
   output logic               vsync_out,
   output logic [23:0]        pixel_out,
   output logic [COORD_W-1:0] centroid_x,
   output logic [COORD_W-1:0] centroid_y,
   output logic               found,
   output logic               centroid_valid
);

   logic               de_d_reg;
   logic               vsync_d_reg;
   logic               frame_end_reg;
   logic               de_fall;
   logic               vs_rise;
   logic [COORD_W-1:0] x_reg;
   logic [COORD_W-1:0] y_reg;
   logic [ACC_W-1:0]   m00_reg;
   logic [ACC_W-1:0]   m10_reg;
   logic [ACC_W-1:0]   m01_reg;
   logic [ACC_W-1:0]   area_reg;
   state_t             state_reg;
   state_t             state_next;
   logic               div_start;
   logic [1:0]         div_busy;
   logic [1:0]         div_done;
   logic [ACC_W-1:0]   dividend_arr [2];
   logic [ACC_W-1:0]   quo_arr      [2];
   logic [COORD_W-1:0] coord_sat    [2];

   assign de_fall = de_d_reg & ~de;
   assign vs_rise = vsync & ~vsync_d_reg;

   // Edge-detect history; the frame-end strobe is registered one clock after vsync rises.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_d_reg      <= 1'b0;
         vsync_d_reg   <= 1'b0;
         frame_end_reg <= 1'b0;
      end else begin
         de_d_reg      <= de;
         vsync_d_reg   <= vsync;
         frame_end_reg <= vs_rise;
      end
   end

   // Pixel coordinates of the sample on pixel_in; held at the last valid index on overlong input.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         x_reg <= '0;
         y_reg <= '0;
      end else begin
         if (de_fall)
            x_reg <= '0;
         else if (de && x_reg != COORD_W'(H_ACTIVE - 1))
            x_reg <= x_reg + COORD_W'(1);

         if (frame_end_reg)
            y_reg <= '0;
         else if (de_fall && y_reg != COORD_W'(V_ACTIVE - 1))
            y_reg <= y_reg + COORD_W'(1);
      end
   end

   // Moment accumulation; frame end clears, and the area is kept only if a division starts.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         m00_reg  <= '0;
         m10_reg  <= '0;
         m01_reg  <= '0;
         area_reg <= '0;
      end else begin
         if (div_start)
            area_reg <= m00_reg;
         if (frame_end_reg) begin
            m00_reg <= '0;
            m10_reg <= '0;
            m01_reg <= '0;
         end else if (de && pixel_in[0]) begin
            m00_reg <= m00_reg + ACC_W'(1);
            m10_reg <= m10_reg + ACC_W'(x_reg);
            m01_reg <= m01_reg + ACC_W'(y_reg);
         end
      end
   end

   assign dividend_arr[0] = m10_reg;
   assign dividend_arr[1] = m01_reg;

   // Two dividers (x then y) share the start strobe and the area divisor.
   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_div
         seq_divider #(.W(ACC_W)) u_div (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (div_start),
            .dividend (dividend_arr[gi]),
            .divisor  (m00_reg),
            .busy     (div_busy[gi]),
            .done     (div_done[gi]),
            .quotient (quo_arr[gi])
         );
         // Centroids always fit COORD_W for in-range frames; clamp rather than wrap otherwise.
         assign coord_sat[gi] = (|quo_arr[gi][ACC_W-1:COORD_W]) ? {COORD_W{1'b1}}
                                                                 : quo_arr[gi][COORD_W-1:0];
      end
   endgenerate

   // Controller state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         state_reg <= IDLE;
      else
         state_reg <= state_next;
   end

   // Next state: a frame end only starts a division from IDLE; otherwise that frame is dropped.
   always_comb begin
      state_next = state_reg;
      div_start  = 1'b0;
      case (state_reg)
         IDLE: begin
            if (frame_end_reg && div_busy == 2'b00) begin
               div_start  = 1'b1;
               state_next = DIV;
            end
         end
         DIV: begin
            if (div_done == 2'b11)
               state_next = DONE;
         end
         DONE:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Result registers: coordinates only move for a large-enough object; valid pulses either way.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         centroid_x     <= '0;
         centroid_y     <= '0;
         found          <= 1'b0;
         centroid_valid <= 1'b0;
      end else begin
         centroid_valid <= 1'b0;
         if (state_reg == DONE) begin
            centroid_valid <= 1'b1;
            if (area_reg >= ACC_W'(MIN_AREA) && area_reg != '0) begin
               centroid_x <= coord_sat[0];
               centroid_y <= coord_sat[1];
               found      <= 1'b1;
            end else begin
               found <= 1'b0;
            end
         end
      end
   end

   // Output stage: syncs delayed untouched, pixel replaced by the marker on the cross lines.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         de_out    <= 1'b0;
         hsync_out <= 1'b0;
         vsync_out <= 1'b0;
         pixel_out <= '0;
      end else begin
         de_out    <= de;
         hsync_out <= hsync;
         vsync_out <= vsync;
         if (de && found && (x_reg == centroid_x || y_reg == centroid_y))
            pixel_out <= MARK_COLOR;
         else
            pixel_out <= pixel_in;
      end
   end

endmodule

// File: tb/tb_centroid_marker.sv
// Bench for centroid_marker: frame-level moment model, per-cycle output compare,
// and literal expectations for the square / full / empty / tiny-object frames.
module tb_centroid_marker;

   localparam int          H        = 64;
   localparam int          V        = 64;
   localparam int          COORD_W  = 11;
   localparam int          ACC_W    = 32;
   localparam int          MIN_AREA = 16;
   localparam int          LAT      = ACC_W + 3;
   localparam logic [23:0] MARK     = 24'hFF0000;

   localparam int K_SQUARE = 0;
   localparam int K_ZERO   = 1;
   localparam int K_FULL   = 2;
   localparam int K_THREE  = 3;
   localparam int K_RAND   = 4;
   localparam int K_RECT   = 5;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               de = 1'b0;
   logic               hsync = 1'b0;
   logic               vsync = 1'b0;
   logic [23:0]        pixel_in = '0;
   logic               de_out;
   logic               hsync_out;
   logic               vsync_out;
   logic [23:0]        pixel_out;
   logic [COORD_W-1:0] centroid_x;
   logic [COORD_W-1:0] centroid_y;
   logic               found;
   logic               centroid_valid;

   always #5 clk = ~clk;

   centroid_marker #(
      .H_ACTIVE (H),
      .V_ACTIVE (V),
      .COORD_W  (COORD_W),
      .ACC_W    (ACC_W),
      .MIN_AREA (MIN_AREA),
      .MARK_COLOR (MARK)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .de             (de),
      .hsync          (hsync),
      .vsync          (vsync),
      .pixel_in       (pixel_in),
      .de_out         (de_out),
      .hsync_out      (hsync_out),
      .vsync_out      (vsync_out),
      .pixel_out      (pixel_out),
      .centroid_x     (centroid_x),
      .centroid_y     (centroid_y),
      .found          (found),
      .centroid_valid (centroid_valid)
   );

   int n_checks = 0;
   int n_fail   = 0;

   // Coordinates of the pixel the driver is presenting this cycle.
   int cur_x = 0;
   int cur_y = 0;
   bit checking = 1'b0;

   // Reference model: what the outputs should currently show, and a pending frame result.
   bit     m_found = 1'b0;
   int     m_cx = 0;
   int     m_cy = 0;
   longint acc00 = 0, acc10 = 0, acc01 = 0;
   bit     pend = 1'b0;
   longint p00 = 0, p10 = 0, p01 = 0;
   longint due = 0;
   longint cyc = 0;
   longint vs_cyc = 0;
   longint lat_seen = -1;
   bit     prev_vs = 1'b0;
   int     mark_cnt = 0;
   logic [23:0] exp_pix;
   bit     exp_valid;

   // Random-mask parameters for the current frame.
   int dens = 0;
   int rx0 = 0, rx1 = 0, ry0 = 0, ry1 = 0;

   task automatic check(input string name, input longint act, input longint req);
      n_checks++;
      if (act != req) begin
         n_fail++;
         $display("FAIL %s @%0t: got %0h, required %0h", name, $time, act, req);
      end
   endtask

   function automatic bit mask_bit(input int kind, input int x, input int y);
      case (kind)
         K_SQUARE: return (x >= 10 && x <= 17 && y >= 20 && y <= 27);
         K_ZERO:   return 1'b0;
         K_FULL:   return 1'b1;
         K_THREE:  return ((x == 5 && y == 5) || (x == 6 && y == 5) || (x == 40 && y == 60));
         K_RAND:   return ($urandom_range(0, 99) < dens);
         K_RECT:   return (x >= rx0 && x <= rx1 && y >= ry0 && y <= ry1);
         default:  return 1'b0;
      endcase
   endfunction

   // Bit 23 kept low so random video can never look like the marker colour.
   function automatic logic [23:0] rand_pix(input bit m);
      logic [21:0] r;
      r = 22'($urandom);
      return {1'b0, r, m};
   endfunction

   // Per-cycle compare against the model, sampled 1 time unit after the active edge.
   always @(posedge clk) begin
      #1;
      cyc++;
      if (!rst_n) begin
         m_found = 1'b0; m_cx = 0; m_cy = 0;
         acc00 = 0; acc10 = 0; acc01 = 0;
         pend = 1'b0; prev_vs = 1'b0; mark_cnt = 0;
      end else if (checking) begin
         exp_pix   = (de && m_found && (cur_x == m_cx || cur_y == m_cy)) ? MARK : pixel_in;
         exp_valid = 1'b0;
         if (de && pixel_in[0]) begin
            acc00 += 1; acc10 += cur_x; acc01 += cur_y;
         end
         if (vsync && !prev_vs) begin
            vs_cyc = cyc;
            if (!(pend && cyc < due)) begin
               pend = 1'b1; due = cyc + LAT;
               p00 = acc00; p10 = acc10; p01 = acc01;
            end
            acc00 = 0; acc10 = 0; acc01 = 0;
            mark_cnt = 0;
         end
         if (pend && cyc == due) begin
            exp_valid = 1'b1;
            pend = 1'b0;
            if (p00 >= MIN_AREA) begin
               m_found = 1'b1; m_cx = int'(p10 / p00); m_cy = int'(p01 / p00);
            end else begin
               m_found = 1'b0;
            end
         end
         check("de_out", de_out, de);
         check("hsync_out", hsync_out, hsync);
         check("vsync_out", vsync_out, vsync);
         check("pixel_out", pixel_out, exp_pix);
         check("centroid_valid", centroid_valid, exp_valid);
         check("found", found, m_found);
         check("centroid_x", centroid_x, m_cx);
         check("centroid_y", centroid_y, m_cy);
         if (centroid_valid) lat_seen = cyc - vs_cyc;
         if (de && pixel_out == MARK) mark_cnt++;
         prev_vs = vsync;
      end
   end

   task automatic idle(input int n);
      repeat (n) begin
         @(negedge clk);
         de = 1'b0; hsync = 1'b0; vsync = 1'b0; pixel_in = rand_pix(1'b0);
      end
   endtask

   task automatic vs_pulse();
      repeat (2) begin
         @(negedge clk);
         de = 1'b0; hsync = 1'b0; vsync = 1'b1; pixel_in = rand_pix(1'b0);
      end
   endtask

   task automatic end_frame();
      vs_pulse();
      idle(40);
   endtask

   task automatic line(input int kind, input int y, input int len);
      repeat (2) begin
         @(negedge clk);
         de = 1'b0; hsync = 1'b1; vsync = 1'b0; pixel_in = rand_pix(1'b0);
      end
      idle(2);
      for (int x = 0; x < len; x++) begin
         @(negedge clk);
         de = 1'b1; hsync = 1'b0; vsync = 1'b0;
         cur_x = x; cur_y = y;
         pixel_in = rand_pix(mask_bit(kind, x, y));
      end
      idle(2);
   endtask

   task automatic frame(input int kind);
      for (int y = 0; y < V; y++) line(kind, y, H);
   endtask

   task automatic check_zero(input string tag);
      check({tag, " de_out"}, de_out, 0);
      check({tag, " hsync_out"}, hsync_out, 0);
      check({tag, " vsync_out"}, vsync_out, 0);
      check({tag, " pixel_out"}, pixel_out, 0);
      check({tag, " centroid_x"}, centroid_x, 0);
      check({tag, " centroid_y"}, centroid_y, 0);
      check({tag, " found"}, found, 0);
      check({tag, " centroid_valid"}, centroid_valid, 0);
   endtask

   task automatic check_result(input string tag, input int cx, input int cy, input int f);
      check({tag, " centroid_x"}, centroid_x, cx);
      check({tag, " centroid_y"}, centroid_y, cy);
      check({tag, " found"}, found, f);
   endtask

   initial begin
      #2;
      check_zero("reset");
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      checking = 1'b1;
      idle(5);
      end_frame();

      // 8x8 square: centroid 13/23, latency ACC_W+3.
      frame(K_SQUARE);
      lat_seen = -1;
      end_frame();
      check("square latency", lat_seen, LAT);
      check_result("square", 13, 23, 1);
      check("model square cx", m_cx, 13);
      check("model square cy", m_cy, 23);

      // Next frame: cross on row 23 and column 13 (64 + 63 pixels).
      frame(K_SQUARE);
      check("cross pixel count", mark_cnt, 127);
      end_frame();

      // Empty mask: found drops, coordinates hold; the cross is still drawn during it.
      frame(K_ZERO);
      check("cross during empty frame", mark_cnt, 127);
      end_frame();
      check_result("empty", 13, 23, 0);

      // Full mask: no cross while it streams; centroid 31/31.
      frame(K_FULL);
      check("no cross after empty", mark_cnt, 0);
      end_frame();
      check_result("full", 31, 31, 1);
      check("model full cx", m_cx, 31);

      // Three pixels: below MIN_AREA, coordinates hold.
      frame(K_THREE);
      check("cross at 31/31", mark_cnt, 127);
      lat_seen = -1;
      end_frame();
      check("tiny valid latency", lat_seen, LAT);
      check_result("tiny", 31, 31, 0);

      // Randomised frames, checked by the model.
      for (int i = 0; i < 3; i++) begin
         dens = $urandom_range(0, 30);
         rx0 = $urandom_range(0, 63); rx1 = $urandom_range(rx0, 63);
         ry0 = $urandom_range(0, 63); ry1 = $urandom_range(ry0, 63);
         frame((i == 1) ? K_RAND : K_RECT);
         end_frame();
      end

      // Frame end while dividing: the short frame in between is dropped.
      rx0 = $urandom_range(0, 40); rx1 = rx0 + 20;
      ry0 = $urandom_range(0, 40); ry1 = ry0 + 20;
      frame(K_RECT);
      vs_pulse();
      idle(2);
      for (int x = 0; x < 8; x++) begin
         @(negedge clk);
         de = 1'b1; hsync = 1'b0; vsync = 1'b0;
         cur_x = x; cur_y = 0; pixel_in = rand_pix(1'b1);
      end
      idle(1);
      vs_pulse();
      idle(40);
      check_result("rect kept", (2 * rx0 + 20) / 2, (2 * ry0 + 20) / 2, 1);
      frame(K_SQUARE);
      end_frame();
      check_result("after discard", 13, 23, 1);

      // Reset in the middle of a division.
      frame(K_FULL);
      vs_pulse();
      idle(10);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check_zero("mid-div reset");
      idle(3);
      rst_n = 1'b1;
      idle(40);
      frame(K_SQUARE);
      end_frame();
      check_result("post reset", 13, 23, 1);
      idle(5);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
